// File: rtl/mvp_pkg.sv
// Shared types and saturating fixed-point helpers for the model-matrix engine.
// Helpers take the element width and fraction as arguments so any parametrisation can reuse them.
package mvp_pkg;

  localparam int MVP_WIDTH   = 16;
  localparam int MVP_FRAC    = 8;
  localparam int MVP_ANGLE_W = 10;
  localparam int ONE         = 1 << MVP_FRAC;

  typedef logic signed [MVP_WIDTH-1:0] fx_t;

  typedef enum logic [1:0] {
    AXIS_X    = 2'd0,
    AXIS_Y    = 2'd1,
    AXIS_Z    = 2'd2,
    AXIS_NONE = 2'd3
  } axis_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUT,
    ST_MUL_C,
    ST_MUL_S,
    ST_ASSEMBLE
  } state_e;

  function automatic logic signed [63:0] fx_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // Round half up, then clamp to a w-bit signed range.
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int w, input int frac);
    logic signed [63:0] p;
    p = a * b + (64'sd1 <<< (frac - 1));
    return fx_sat(p >>> frac, w);
  endfunction

  function automatic logic signed [63:0] fx_neg_sat(input logic signed [63:0] a, input int w);
    return fx_sat(-a, w);
  endfunction

endpackage

// File: rtl/trig_lut.sv
// Quarter-wave sine ROM with quadrant folding; sin and cos registered, one cycle latency.
module trig_lut #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int ANGLE_W = 10
) (
  input  logic                      clk,
  input  logic [ANGLE_W-1:0]        angle,
  output logic signed [WIDTH-1:0]   sin_val,
  output logic signed [WIDTH-1:0]   cos_val
);

  localparam int  N  = 1 << (ANGLE_W - 2);
  localparam real PI = 3.14159265358979323846;

  // Taylor series in real arithmetic so the table is fixed at elaboration time.
  function automatic int sin_tab(input int i);
    real x;
    real term;
    real sum;
    if (i >= N) return 1 << FRAC;
    x    = 2.0 * PI * real'(i) / real'(4 * N);
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return $rtoi(sum * real'(1 << FRAC) + 0.5);
  endfunction

  logic signed [WIDTH-1:0] rom [N+1];

  for (genvar g = 0; g <= N; g++) begin : g_rom
    localparam logic signed [WIDTH-1:0] TV = WIDTH'(sin_tab(g));
    assign rom[g] = TV;
  end

  function automatic logic signed [WIDTH-1:0] fold(input logic [1:0] quad,
                                                  input logic signed [WIDTH-1:0] t_dir,
                                                  input logic signed [WIDTH-1:0] t_mir);
    case (quad)
      2'd0:    return t_dir;
      2'd1:    return t_mir;
      2'd2:    return -t_dir;
      default: return -t_mir;
    endcase
  endfunction

  logic [ANGLE_W-1:0] cos_ang;
  logic [ANGLE_W-2:0] s_idx, s_mir, c_idx, c_mir;
  logic signed [WIDTH-1:0] sin_d, cos_d, sin_q, cos_q;

  always_comb begin
    cos_ang = angle + ANGLE_W'(N);
    s_idx   = {1'b0, angle[ANGLE_W-3:0]};
    c_idx   = {1'b0, cos_ang[ANGLE_W-3:0]};
    s_mir   = (ANGLE_W-1)'(N) - s_idx;
    c_mir   = (ANGLE_W-1)'(N) - c_idx;
    sin_d   = fold(angle[ANGLE_W-1:ANGLE_W-2], rom[s_idx], rom[s_mir]);
    cos_d   = fold(cos_ang[ANGLE_W-1:ANGLE_W-2], rom[c_idx], rom[c_mir]);
  end

  always_ff @(posedge clk) begin
    sin_q <= sin_d;
    cos_q <= cos_d;
  end

  assign sin_val = sin_q;
  assign cos_val = cos_q;

endmodule

// File: rtl/model_matrix_engine.sv
// Sequential 4x4 model-matrix builder: latch request, look up sin/cos, two shared multiplies, assemble.
// Done strobes 4 cycles after start is accepted; start is ignored while busy.
module model_matrix_engine
  import mvp_pkg::*;
#(
  parameter int WIDTH   = MVP_WIDTH,
  parameter int FRAC    = MVP_FRAC,
  parameter int ANGLE_W = MVP_ANGLE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               axis,
  input  logic [ANGLE_W-1:0]       angle,
  input  logic signed [WIDTH-1:0]  scale,
  input  logic signed [WIDTH-1:0]  x_translate,
  input  logic signed [WIDTH-1:0]  y_translate,
  input  logic signed [WIDTH-1:0]  z_translate,
  output logic                     busy,
  output logic                     done,
  output logic [15:0][WIDTH-1:0]   model_matrix
);

  localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(1) << FRAC;

  function automatic logic [15:0][WIDTH-1:0] ident_mat();
    logic [15:0][WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = ONE_W;
    return m;
  endfunction

  localparam logic [15:0][WIDTH-1:0] IDENT = ident_mat();

  state_e                   state_q, state_d;
  axis_e                    axis_q, axis_d;
  logic [ANGLE_W-1:0]       angle_q, angle_d;
  logic signed [WIDTH-1:0]  scale_q, scale_d, tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
  logic signed [WIDTH-1:0]  sc_q, sc_d, ss_q, ss_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [15:0][WIDTH-1:0]   mat_q, mat_d, asm_m;
  logic signed [WIDTH-1:0]  sin_v, cos_v, nss;

  trig_lut #(.WIDTH(WIDTH), .FRAC(FRAC), .ANGLE_W(ANGLE_W)) u_trig (
    .clk     (clk),
    .angle   (angle_q),
    .sin_val (sin_v),
    .cos_val (cos_v)
  );

  always_comb begin
    nss      = WIDTH'(fx_neg_sat(64'(ss_q), WIDTH));
    asm_m    = '0;
    asm_m[3]  = tx_q;
    asm_m[7]  = ty_q;
    asm_m[11] = tz_q;
    asm_m[15] = ONE_W;
    case (axis_q)
      AXIS_X: begin
        asm_m[0] = scale_q; asm_m[5] = sc_q; asm_m[6] = nss;
        asm_m[9] = ss_q;    asm_m[10] = sc_q;
      end
      AXIS_Y: begin
        asm_m[0] = sc_q;    asm_m[2] = ss_q; asm_m[5] = scale_q;
        asm_m[8] = nss;     asm_m[10] = sc_q;
      end
      AXIS_Z: begin
        asm_m[0] = sc_q;    asm_m[1] = nss;  asm_m[4] = ss_q;
        asm_m[5] = sc_q;    asm_m[10] = scale_q;
      end
      default: begin
        asm_m[0] = scale_q; asm_m[5] = scale_q; asm_m[10] = scale_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    angle_d = angle_q;
    scale_d = scale_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    tz_d    = tz_q;
    sc_d    = sc_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mat_d   = mat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          axis_d  = axis_e'(axis);
          angle_d = angle;
          scale_d = scale;
          tx_d    = x_translate;
          ty_d    = y_translate;
          tz_d    = z_translate;
          busy_d  = 1'b1;
          state_d = ST_LUT;
        end
      end
      ST_LUT:   state_d = ST_MUL_C;
      ST_MUL_C: begin
        sc_d    = WIDTH'(fx_mul(64'(scale_q), 64'(cos_v), WIDTH, FRAC));
        state_d = ST_MUL_S;
      end
      ST_MUL_S: begin
        ss_d    = WIDTH'(fx_mul(64'(scale_q), 64'(sin_v), WIDTH, FRAC));
        state_d = ST_ASSEMBLE;
      end
      ST_ASSEMBLE: begin
        mat_d   = asm_m;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      axis_q  <= AXIS_NONE;
      angle_q <= '0;
      scale_q <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      tz_q    <= '0;
      sc_q    <= '0;
      ss_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mat_q   <= IDENT;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      angle_q <= angle_d;
      scale_q <= scale_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      sc_q    <= sc_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mat_q   <= mat_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign model_matrix = mat_q;

endmodule

// File: tb/tb_model_matrix_engine.sv
// Randomised bench for model_matrix_engine against a trigonometric reference model.
module tb_model_matrix_engine;

  typedef logic [15:0][15:0] mat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  axis = '0;
  logic [9:0]  angle = '0;
  logic [15:0] scale = '0, x_translate = '0, y_translate = '0, z_translate = '0;
  logic        busy, done;
  mat_t        model_matrix;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  model_matrix_engine #(.WIDTH(16), .FRAC(8), .ANGLE_W(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .axis         (axis),
    .angle        (angle),
    .scale        (scale),
    .x_translate  (x_translate),
    .y_translate  (y_translate),
    .z_translate  (z_translate),
    .busy         (busy),
    .done         (done),
    .model_matrix (model_matrix)
  );

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat16((a * b + 128) >>> 8);
  endfunction

  function automatic longint to_fx(input real r);
    real t;
    t = r * 256.0;
    if (t >= 0.0) return longint'($rtoi(t + 0.5));
    return -longint'($rtoi(-t + 0.5));
  endfunction

  function automatic mat_t model(input logic [1:0] ax, input logic [9:0] ang,
                                 input logic [15:0] sc_in, input logic [15:0] tx,
                                 input logic [15:0] ty, input logic [15:0] tz);
    real    th;
    longint s, c, sv, ns, sn, cs;
    longint e [16];
    mat_t   m;
    th = 2.0 * 3.14159265358979323846 * real'(ang) / 1024.0;
    s  = longint'($signed(sc_in));
    sn = to_fx($sin(th));
    cs = to_fx($cos(th));
    c  = fmul(s, cs);
    sv = fmul(s, sn);
    ns = sat16(-sv);
    for (int i = 0; i < 16; i++) e[i] = 0;
    e[3]  = longint'($signed(tx));
    e[7]  = longint'($signed(ty));
    e[11] = longint'($signed(tz));
    e[15] = 256;
    case (ax)
      2'd0: begin e[0] = s; e[5] = c; e[6] = ns; e[9] = sv; e[10] = c; end
      2'd1: begin e[0] = c; e[2] = sv; e[5] = s; e[8] = ns; e[10] = c; end
      2'd2: begin e[0] = c; e[1] = ns; e[4] = sv; e[5] = c; e[10] = s; end
      default: begin e[0] = s; e[5] = s; e[10] = s; end
    endcase
    for (int i = 0; i < 16; i++) m[i] = 16'(e[i]);
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    return m;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chkm(input string name, input mat_t got, input mat_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference timeline: an accepted request surfaces 4 edges later.
  mat_t exp_mat, pend;
  int   cnt;
  logic exp_busy, exp_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_mat  <= ident();
    end else begin
      exp_done <= 1'b0;
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          exp_mat  <= pend;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
        end
      end else if (start) begin
        pend     <= model(axis, angle, scale, x_translate, y_translate, z_translate);
        cnt      <= 4;
        exp_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", longint'(busy), longint'(exp_busy));
      chk("done", longint'(done), longint'(exp_done));
      chkm("matrix", model_matrix, exp_mat);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rand_inputs();
    axis        = 2'($urandom);
    angle       = 10'($urandom);
    case ($urandom_range(0, 3))
      0:       scale = 16'h8000;
      1:       scale = 16'h7FFF;
      default: scale = 16'($urandom);
    endcase
    x_translate = 16'($urandom);
    y_translate = 16'($urandom);
    z_translate = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
  endtask

  task automatic set_in(input logic [1:0] ax, input logic [9:0] ang, input logic [15:0] sc,
                        input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] tz);
    axis = ax; angle = ang; scale = sc;
    x_translate = tx; y_translate = ty; z_translate = tz;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   cyc, cyc2;
    mat_t pm;

    pm = model(2'd1, 10'd128, 16'h0176, 16'h0234, 16'h0416, 16'h0396);
    chk("model_y45_0", longint'(pm[0]), 'h0108);
    chk("model_y45_8", longint'(pm[8]), 'hFEF8);
    pm = model(2'd1, 10'd256, 16'h8000, 16'h0, 16'h0, 16'h0);
    chk("model_negsat_8", longint'(pm[8]), 'h7FFF);

    step();
    chk_en = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chkm("rst_identity", model_matrix, ident());

    // Y axis, pi/4.
    set_in(2'd1, 10'd128, 16'h0176, 16'h0234, 16'h0416, 16'h0396);
    pulse();
    rand_inputs();
    wait_done(cyc);
    chk("t2_latency", longint'(cyc), 4);
    chk("t2_m0", longint'(model_matrix[0]), 'h0108);
    chk("t2_m2", longint'(model_matrix[2]), 'h0108);
    chk("t2_m10", longint'(model_matrix[10]), 'h0108);
    chk("t2_m8", longint'(model_matrix[8]), 'hFEF8);
    chk("t2_m5", longint'(model_matrix[5]), 'h0176);
    chk("t2_m3", longint'(model_matrix[3]), 'h0234);
    chk("t2_m7", longint'(model_matrix[7]), 'h0416);
    chk("t2_m11", longint'(model_matrix[11]), 'h0396);
    chk("t2_m15", longint'(model_matrix[15]), 'h0100);
    chk("t2_m1", longint'(model_matrix[1]), 0);
    chk("t2_m6", longint'(model_matrix[6]), 0);

    // X axis, pi/2.
    set_in(2'd0, 10'd256, 16'h0200, 16'h0, 16'h0, 16'h0);
    pulse();
    wait_done(cyc);
    chk("t3_m0", longint'(model_matrix[0]), 'h0200);
    chk("t3_m5", longint'(model_matrix[5]), 0);
    chk("t3_m6", longint'(model_matrix[6]), 'hFE00);
    chk("t3_m9", longint'(model_matrix[9]), 'h0200);
    chk("t3_m10", longint'(model_matrix[10]), 0);
    chk("t3_m15", longint'(model_matrix[15]), 'h0100);

    // Most negative scale: negation must saturate.
    set_in(2'd1, 10'd256, 16'h8000, 16'h0, 16'h0, 16'h0);
    pulse();
    wait_done(cyc);
    chk("t4_m2", longint'(model_matrix[2]), 'h8000);
    chk("t4_m8", longint'(model_matrix[8]), 'h7FFF);
    chk("t4_m0", longint'(model_matrix[0]), 0);
    chk("t4_m10", longint'(model_matrix[10]), 0);

    set_in(2'd2, 10'd768, 16'h0100, 16'h0, 16'h0, 16'h0);
    pulse();
    wait_done(cyc);
    chk("t5_m0", longint'(model_matrix[0]), 0);
    chk("t5_m5", longint'(model_matrix[5]), 0);
    chk("t5_m1", longint'(model_matrix[1]), 'h0100);
    chk("t5_m4", longint'(model_matrix[4]), 'hFF00);

    set_in(2'd3, 10'($urandom), 16'h0123, 16'h0, 16'h0, 16'h0);
    pulse();
    wait_done(cyc);
    chk("t5n_m0", longint'(model_matrix[0]), 'h0123);
    chk("t5n_m5", longint'(model_matrix[5]), 'h0123);
    chk("t5n_m10", longint'(model_matrix[10]), 'h0123);
    chk("t5n_m1", longint'(model_matrix[1]), 0);

    // Second start while busy is dropped.
    set_in(2'd0, 10'd256, 16'h0200, 16'h0, 16'h0, 16'h0);
    pulse();
    set_in(2'd2, 10'd100, 16'h7000, 16'h1111, 16'h2222, 16'h3333);
    pulse();
    wait_done(cyc);
    chk("t6a_m6", longint'(model_matrix[6]), 'hFE00);
    chk("t6a_m9", longint'(model_matrix[9]), 'h0200);
    chk("t6a_m3", longint'(model_matrix[3]), 0);

    // Reset while in MUL_C.
    set_in(2'd1, 10'd128, 16'h0176, 16'h0234, 16'h0416, 16'h0396);
    pulse();
    step();
    reset_n = 1'b0;
    #1;
    chk("t6b_busy", longint'(busy), 0);
    chkm("t6b_identity", model_matrix, ident());
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6b_no_done", longint'(done), 0);
    end
    chkm("t6b_identity_hold", model_matrix, ident());

    // Back-to-back: restart in the done cycle.
    set_in(2'd1, 10'd128, 16'h0176, 16'h0234, 16'h0416, 16'h0396);
    pulse();
    wait_done(cyc);
    set_in(2'd0, 10'd256, 16'h0200, 16'h0, 16'h0, 16'h0);
    pulse();
    wait_done(cyc2);
    chk("t6c_gap", longint'(cyc2 + 1), 5);
    chk("t6c_m6", longint'(model_matrix[6]), 'hFE00);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      start   = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 59) != 0);
      step();
    end
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/model_matrix_engine.md
Name: model_matrix_engine

Overview:
Sequential, parametrised successor to the combinational model-matrix generator. On a start pulse it latches angle, scale and translation and selects the rotation axis (X, Y, Z or none). It then computes the 4x4 row-major fixed-point model matrix through a quarter-wave sin/cos ROM and one shared multiplier. It sits ahead of the view/projection stages in the MVP chain and presents the result with a one-cycle done strobe.

Parameters:
- WIDTH, 16: signed fixed-point element width.
- FRAC, 8: fraction bits; WIDTH-FRAC >= 2 so that 1.0 is representable.
- ANGLE_W, 10: binary-angle width; full turn = 2^ANGLE_W; quarter ROM holds 2^(ANGLE_W-2)+1 entries.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- axis  in  2  rotation axis: 0=X, 1=Y, 2=Z, 3=none (scale + translate only).
- angle  in  ANGLE_W  unsigned binary angle; wraps modulo full turn.
- scale  in  WIDTH  signed Q(WIDTH-FRAC).FRAC uniform scale.
- x_translate, y_translate, z_translate  in  WIDTH each  signed fixed-point translation.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle strobe; matrix is valid from that cycle.
- model_matrix  out  [15:0][WIDTH-1:0]  element index = row*4+col.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; busy=0; done=0; model_matrix=identity (indices 0,5,10,15 = 1<<FRAC, all others 0).
- FSM: IDLE -> LUT -> MUL_C -> MUL_S -> ASSEMBLE -> IDLE.
  - IDLE: start=1 latches all inputs and moves to LUT.
  - LUT: quadrant = angle[ANGLE_W-1:ANGLE_W-2], idx = remaining bits, N = 2^(ANGLE_W-2).
    - sin: q0 = T[idx], q1 = T[N-idx], q2 = -T[idx], q3 = -T[N-idx].
    - cos = sin(angle+N) mod 2^ANGLE_W.
    - ROM is registered, one cycle.
  - MUL_C: sc = fx_mul(scale, cos).
  - MUL_S: ss = fx_mul(scale, sin).
  - ASSEMBLE: register the full matrix, assert done for one cycle, drop busy.
- Latency: start sampled at edge E0, done high after edge E4, i.e. exactly 4 cycles later. Throughput is one matrix per 5 cycles; start may be asserted in the cycle done is high and is accepted from IDLE on the next edge.
- fx_mul: full 2*WIDTH signed product, add 2^(FRAC-1), arithmetic shift right by FRAC, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Negation also saturates (-min -> max).
- Matrix layout (rows 0..2; row 3 always 0,0,0,1<<FRAC; column 3 = x, y, z):
  - X: [s,0,0] [0,sc,-ss] [0,ss,sc]
  - Y: [sc,0,ss] [0,s,0] [-ss,0,sc]
  - Z: [sc,-ss,0] [ss,sc,0] [0,0,s]
  - none: [s,0,0] [0,s,0] [0,0,s]
- ROM: T[i] = round(sin(i*2pi/2^ANGLE_W) * 2^FRAC), i = 0..N; T[N] = 1<<FRAC.
- start while busy: ignored, no queuing.
- Input changes after acceptance have no effect on the computation in flight.
- model_matrix changes only in ASSEMBLE (or on reset) and holds its value otherwise.
- reset_n low mid-computation: immediate abort, outputs return to reset values, no done.

Decomposition:
- Package mvp_pkg:
  - fixed-point element typedef sized by WIDTH;
  - axis enum (AXIS_X, AXIS_Y, AXIS_Z, AXIS_NONE);
  - FSM state enum;
  - ONE = 1<<FRAC;
  - fx_mul and fx_neg_sat functions.
- Sub-module trig_lut: quarter-wave ROM plus quadrant folding.
  - Inputs: clk, angle.
  - Outputs: registered sin and cos, 1-cycle latency.
  - Generated from parameters via an initial or constant function.

Test Plan (WIDTH=16, FRAC=8, ANGLE_W=10):
1. Reset, then idle: model_matrix[0],[5],[10],[15] = 0x0100, all other elements 0; busy=0; done=0.
2. axis=Y, angle=128 (pi/4), scale=0x0176, x=0x0234, y=0x0416, z=0x0396, one start pulse -> done exactly 4 cycles later with:
   - [0]=[2]=[10]=0x0108, [8]=0xFEF8;
   - [5]=0x0176;
   - [3]=0x0234, [7]=0x0416, [11]=0x0396, [15]=0x0100;
   - all other elements 0.
3. axis=X, angle=256 (pi/2), scale=0x0200, translation 0 -> [0]=0x0200, [5]=0, [6]=0xFE00, [9]=0x0200, [10]=0, [15]=0x0100.
4. axis=Y, angle=256, scale=0x8000 -> [2]=0x8000, [8]=0x7FFF (saturated negation), [0]=[10]=0.
5. Wrap and mode checks:
   - angle=768 (3pi/2), axis=Z, scale=0x0100 -> [0]=[5]=0, [1]=0x0100, [4]=0xFF00.
   - axis=3 -> diagonal = scale regardless of angle.
6. Handshake and reset:
   - Start pulsed again during busy with different inputs -> ignored, result matches the first request.
   - reset_n low in MUL_C -> no done, identity matrix.
   - Back-to-back start in the done cycle -> second done 5 cycles after the first.
